// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber modulus constants, zeta table and inverse-NTT state type
// Contents:
//   KYBER_Q, KYBER_N, KYBER_N_INV, BARRETT_M  arithmetic constants
//   ZETAS[128]                                 17^bitrev7(i) mod Q, natural-domain twiddles
//   intt_state_t                               LOAD / COMPUTE / SCALE / UNLOAD
//   mod_q_reduce()                             single conditional subtract for values below 2Q
package kyber_pkg;

    localparam logic [12:0] KYBER_Q     = 13'd3329;
    localparam int          KYBER_N     = 256;
    localparam logic [11:0] KYBER_N_INV = 12'd3303;
    localparam logic [12:0] BARRETT_M   = 13'd5039;

    localparam logic [11:0] ZETAS [0:127] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        SCALE   = 2'd2,
        UNLOAD  = 2'd3
    } intt_state_t;

    // Input must be below 2Q.
    function automatic logic [11:0] mod_q_reduce(input logic [12:0] x);
        if (x >= KYBER_Q)
            return 12'(x - KYBER_Q);
        else
            return x[11:0];
    endfunction

endpackage

// File: rtl/intt_mod_mul.sv
// rtl/intt_mod_mul.sv - combinational 12x12 modular multiply with Barrett reduction mod Q
// Ports:
//   i_a, i_b  operands in [0,Q-1]
//   o_p       (i_a*i_b) mod Q in [0,Q-1]
module intt_mod_mul
    import kyber_pkg::*;
(
    input  logic [11:0] i_a,
    input  logic [11:0] i_b,
    output logic [11:0] o_p
);

    logic [23:0] w_prod;
    logic [36:0] w_est;
    logic [12:0] w_qhat;
    logic [23:0] w_rem;
    logic        w_unused_bits;

    assign w_prod = 24'(i_a) * 24'(i_b);
    // floor(p*m/2^24) underestimates p/Q by at most one, so the remainder is below 2Q.
    assign w_est  = 37'(w_prod) * 37'(BARRETT_M);
    assign w_qhat = w_est[36:24];
    assign w_rem  = w_prod - 24'(w_qhat) * 24'(KYBER_Q);
    assign o_p    = mod_q_reduce(w_rem[12:0]);

    assign w_unused_bits = ^{w_rem[23:13], w_est[23:0]};

endmodule

// File: rtl/ntt_inverse_seq.sv
// rtl/ntt_inverse_seq.sv - sequential Kyber inverse NTT, one shared butterfly over a 256x12 buffer
// Optional feature macro: INTT_SCALE_EN (adds SCALE pass multiplying by N_INV; otherwise out = 128*f mod Q)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_data[11:0] NTT-domain coefficient (upper bits ignored)
//   out_valid/out_ready  output handshake, out_data coefficient-domain value zero-extended
//   busy                 high during COMPUTE or SCALE
//   done                 one-cycle pulse after the last output beat is accepted
module ntt_inverse_seq
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        done
);

    intt_state_t r_state, w_state_nxt;
    logic [7:0]  r_idx, w_idx_nxt;
    logic [2:0]  r_layer, w_layer_nxt;
    logic [6:0]  r_k, w_k_nxt;
    logic        r_done, w_done_nxt;
    logic [11:0] r_buf [KYBER_N];

    logic [7:0]  w_len, w_mask, w_c, w_j, w_jl;
    logic [11:0] w_a, w_b, w_sum, w_diff;
    logic [12:0] w_diff13;
    logic [11:0] w_mul_a, w_mul_b, w_mul_p;
    logic        w_blk_end;
    logic        w_unused_in;

    assign w_unused_in = ^in_data[15:12];

    // Butterfly addressing: counter c (0..127) splits into block (upper bits) and
    // offset (lower log2(len) bits); j = block*2*len + offset.
    assign w_len     = 8'd2 << r_layer;
    assign w_mask    = w_len - 8'd1;
    assign w_c       = {1'b0, r_idx[6:0]};
    assign w_j       = ((w_c & ~w_mask) << 1) | (w_c & w_mask);
    assign w_jl      = w_j + w_len;
    assign w_blk_end = ((w_c & w_mask) == w_mask);

    assign w_a      = r_buf[w_j];
    assign w_b      = r_buf[w_jl];
    assign w_sum    = mod_q_reduce({1'b0, w_a} + {1'b0, w_b});
    assign w_diff13 = {1'b0, w_b} + (KYBER_Q - {1'b0, w_a});
    assign w_diff   = mod_q_reduce(w_diff13);

    // One multiplier serves the butterfly twiddle and the final N_INV scaling.
    assign w_mul_a = (r_state == COMPUTE) ? w_diff      : r_buf[r_idx];
    assign w_mul_b = (r_state == COMPUTE) ? ZETAS[r_k]  : KYBER_N_INV;

    intt_mod_mul u_mod_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_mul_p)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_layer_nxt = r_layer;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        case (r_state)
            LOAD: begin
                if (in_valid) begin
                    w_idx_nxt = r_idx + 8'd1;
                    if (r_idx == 8'd255) begin
                        w_state_nxt = COMPUTE;
                        w_layer_nxt = 3'd0;
                        w_k_nxt     = 7'd127;
                    end
                end
            end
            COMPUTE: begin
                if (w_blk_end)
                    w_k_nxt = r_k - 7'd1;
                if (r_idx[6:0] == 7'd127) begin
                    w_idx_nxt = 8'd0;
                    if (r_layer == 3'd6) begin
`ifdef INTT_SCALE_EN
                        w_state_nxt = SCALE;
`else
                        w_state_nxt = UNLOAD;
`endif
                    end else begin
                        w_layer_nxt = r_layer + 3'd1;
                    end
                end else begin
                    w_idx_nxt = r_idx + 8'd1;
                end
            end
            SCALE: begin
                w_idx_nxt = r_idx + 8'd1;
                if (r_idx == 8'd255)
                    w_state_nxt = UNLOAD;
            end
            UNLOAD: begin
                if (out_ready) begin
                    w_idx_nxt = r_idx + 8'd1;
                    if (r_idx == 8'd255) begin
                        w_state_nxt = LOAD;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_idx   <= 8'd0;
            r_layer <= 3'd0;
            r_k     <= 7'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_layer <= w_layer_nxt;
            r_k     <= w_k_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Coefficient buffer needs no reset; every entry is rewritten during LOAD.
    always_ff @(posedge clk) begin
        if (r_state == LOAD && in_valid) begin
            r_buf[r_idx] <= in_data[11:0];
        end else if (r_state == COMPUTE) begin
            r_buf[w_j]  <= w_sum;
            r_buf[w_jl] <= w_mul_p;
        end
`ifdef INTT_SCALE_EN
        else if (r_state == SCALE) begin
            r_buf[r_idx] <= w_mul_p;
        end
`endif
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == UNLOAD);
    assign out_data  = (r_state == UNLOAD) ? {4'd0, r_buf[r_idx]} : 16'd0;
    assign busy      = (r_state == COMPUTE) || (r_state == SCALE);
    assign done      = r_done;

endmodule

// File: tb/tb_ntt_inverse_seq.sv
// tb/tb_ntt_inverse_seq.sv - scoreboard bench: random x, feed NTT(x), expect x (or 128*x) back
module tb_ntt_inverse_seq;

    localparam int Q = 3329;
    localparam int P = 10;
`ifdef INTT_SCALE_EN
    localparam int LAT      = 1152;
    localparam int OUT_MULT = 1;
`else
    localparam int LAT      = 896;
    localparam int OUT_MULT = 128;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    ntt_inverse_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #(P/2) clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     zeta [128];
    int     x [256];
    int     f [256];
    int     exp_q [$];
    longint t0_q [$];
    int     ready_pct = 100;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at time %0t", name, $time);
    endtask

    function automatic int bitrev7(input int v);
        int r = 0;
        for (int b = 0; b < 7; b++)
            if ((v >> b) & 1) r |= 1 << (6 - b);
        return r;
    endfunction

    function automatic int powmod(input int base, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * base) % Q;
        return r;
    endfunction

    // Forward NTT (FIPS 203 Alg. 9) of x into f.
    task automatic fwd_ntt();
        int k = 1;
        int t;
        for (int i = 0; i < 256; i++) f[i] = x[i];
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int s = 0; s < 256; s += 2 * len) begin
                int z;
                z = zeta[k];
                k++;
                for (int j = s; j < s + len; j++) begin
                    t          = (z * f[j + len]) % Q;
                    f[j + len] = (f[j] - t + Q) % Q;
                    f[j]       = (f[j] + t) % Q;
                end
            end
        end
    endtask

    task automatic rand_x();
        for (int i = 0; i < 256; i++) x[i] = int'($urandom_range(Q - 1));
    endtask

    task automatic send_poly();
        for (int i = 0; i < 256; i++) exp_q.push_back((x[i] * OUT_MULT) % Q);
        for (int i = 0; i < 256; i++) begin
            int w = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {4'($urandom_range(15)), 12'(f[i])};
            while (!in_ready && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                fail_now("in_ready_timeout");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        t0_q.push_back(longint'($time));
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on every accepted output beat.
    initial begin
        bit prev_valid = 0;
        bit prev_stall = 0;
        int prev_data  = 0;
        int beat       = 0;
        bit exp_done   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0; prev_stall = 0; beat = 0; exp_done = 0;
                continue;
            end
            check("done_pulse", int'(done), int'(exp_done));
            if (exp_done) check("ready_after_done", int'(in_ready), 1);
            exp_done = 0;
            if (out_valid) begin
                if (!prev_valid) begin
                    if (t0_q.size() == 0) begin
                        fail_now("output_without_input");
                    end else begin
                        longint t0;
                        t0 = t0_q.pop_front();
                        check("latency", int'((longint'($time) - t0 - P/2) / P), LAT);
                        check("busy_in_unload", int'(busy), 0);
                    end
                end
                check("in_ready_in_unload", int'(in_ready), 0);
                if (prev_stall) check("stall_hold", int'(out_data), prev_data);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        check("out_data", int'(out_data), exp_q.pop_front());
                    end
                    beat++;
                    if (beat == 256) begin
                        beat = 0;
                        exp_done = 1;
                    end
                end
            end
            prev_valid = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) zeta[i] = powmod(17, bitrev7(i));

        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // All-zero polynomial.
        for (int i = 0; i < 256; i++) x[i] = 0;
        fwd_ntt();
        send_poly();
        wait_drain();

        // Delta at x[0].
        x[0] = 1;
        fwd_ntt();
        send_poly();
        wait_drain();

        // Three random polynomials back-to-back.
        for (int p = 0; p < 3; p++) begin
            rand_x();
            fwd_ntt();
            send_poly();
        end
        wait_drain();

        // Output back-pressure at roughly 30% ready duty.
        ready_pct = 30;
        rand_x();
        fwd_ntt();
        send_poly();
        wait_drain();
        ready_pct = 100;

        // Abort during the len=16 layer, then a fresh polynomial.
        rand_x();
        fwd_ntt();
        send_poly();
        repeat (424) @(negedge clk);
        check("busy_mid_compute", int'(busy), 1);
        rst_n = 1'b0;
        exp_q.delete();
        t0_q.delete();
        @(negedge clk);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_done", int'(done), 0);
        rst_n = 1'b1;
        rand_x();
        fwd_ntt();
        send_poly();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
